// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse playback block.
//   Scancodes that play as Morse symbols, unit counts per element, and FSM states.
package morse_pkg;

  localparam int unsigned UNITS_W = 2;

  // Keyboard scancodes that play as Morse symbols
  localparam logic [7:0] SC_DOT   = 8'h49;
  localparam logic [7:0] SC_DASH  = 8'h4E;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Length of each element in Morse time units
  localparam logic [UNITS_W-1:0] DOT_UNITS         = UNITS_W'(1);
  localparam logic [UNITS_W-1:0] DASH_UNITS        = UNITS_W'(3);
  localparam logic [UNITS_W-1:0] SPACE_EXTRA_UNITS = UNITS_W'(2);
  localparam logic [UNITS_W-1:0] GAP_UNITS         = UNITS_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_DECODE,
    ST_ON,
    ST_GAP,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/morse_unit_timer.sv
// Times an element of load_units Morse units, each UNIT_CYCLES clocks long.
//   clock, resetn : clock and asynchronous active-low reset
//   clear         : restart timing on the next edge and latch load_units
//   load_units    : element length in units (1..3)
//   expired       : high during the final cycle of the element (registered)
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25_000_000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic [UNITS_W-1:0] load_units,
  output logic               expired
);

  localparam int unsigned CYC_W = $clog2(UNIT_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  logic [CYC_W-1:0]   cyc_q, cyc_n;
  logic [UNITS_W-1:0] unit_q, unit_n;
  logic [UNITS_W-1:0] units_q;

  // Free-running cycle counter; unit counter advances on each wrap
  always_comb begin
    cyc_n  = cyc_q + CYC_W'(1);
    unit_n = unit_q;
    if (cyc_q == CYC_LAST) begin
      cyc_n  = '0;
      unit_n = unit_q + UNITS_W'(1);
    end
  end

  // expired is predicted one cycle ahead so it can be registered without lag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cyc_q   <= '0;
      unit_q  <= '0;
      units_q <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cyc_q   <= '0;
      unit_q  <= '0;
      units_q <= load_units;
      expired <= 1'b0;
    end else begin
      cyc_q   <= cyc_n;
      unit_q  <= unit_n;
      expired <= (cyc_n == CYC_LAST) && (unit_n == units_q - UNITS_W'(1));
    end
  end

endmodule

// File: rtl/morse_playback.sv
// Replays stored keyboard scancodes as a timed Morse signal on one LED.
//   clock, resetn : clock and asynchronous active-low reset
//   start         : one-cycle playback request, honoured only when idle
//   msg_len       : number of stored entries (latched at start)
//   rd_addr       : RAM read address
//   rd_data       : RAM data, valid one cycle after rd_addr
//   led           : Morse output, 1 = on
//   busy          : playback in progress
//   done          : one-cycle pulse at the end of playback
module morse_playback
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25_000_000,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] msg_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              led,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_n;
  logic [ADDR_W-1:0]  index_q;
  logic [ADDR_W-1:0]  len_q;
  logic [7:0]         code_q;
  logic               timer_clear;
  logic [UNITS_W-1:0] timer_load;
  logic               timer_expired;
  logic               accept;
  logic               last_entry;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (timer_clear),
    .load_units(timer_load),
    .expired   (timer_expired)
  );

  assign accept     = (state_q == ST_IDLE) && start && (msg_len != '0);
  assign last_entry = (index_q == len_q - ADDR_W'(1));

  // Next-state logic; the timer is cleared on the edge that enters ON or GAP
  always_comb begin
    state_n     = state_q;
    timer_clear = 1'b0;
    timer_load  = GAP_UNITS;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_n = (msg_len == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH:   state_n = ST_WAIT_RD;
      ST_WAIT_RD: state_n = ST_DECODE;
      ST_DECODE: begin
        case (code_q)
          SC_DOT: begin
            state_n     = ST_ON;
            timer_clear = 1'b1;
            timer_load  = DOT_UNITS;
          end
          SC_DASH: begin
            state_n     = ST_ON;
            timer_clear = 1'b1;
            timer_load  = DASH_UNITS;
          end
          SC_SPACE: begin
            // Letter gap: these units plus the preceding element's trailing gap
            state_n     = ST_GAP;
            timer_clear = 1'b1;
            timer_load  = SPACE_EXTRA_UNITS;
          end
          default: state_n = ST_NEXT;
        endcase
      end
      ST_ON: begin
        if (timer_expired) begin
          state_n     = ST_GAP;
          timer_clear = 1'b1;
          timer_load  = GAP_UNITS;
        end
      end
      ST_GAP: begin
        if (timer_expired) state_n = ST_NEXT;
      end
      ST_NEXT: state_n = last_entry ? ST_DONE : ST_FETCH;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs decoded from next state)
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      len_q   <= '0;
      code_q  <= '0;
      rd_addr <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        index_q <= '0;
        len_q   <= msg_len;
        rd_addr <= '0;
      end
      if (state_q == ST_WAIT_RD) code_q <= rd_data;
      if ((state_q == ST_NEXT) && !last_entry) begin
        index_q <= index_q + ADDR_W'(1);
        rd_addr <= index_q + ADDR_W'(1);
      end
      // Park the read address at 0 between runs
      if (state_n == ST_DONE) rd_addr <= '0;
      led  <= (state_n == ST_ON);
      busy <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      done <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_morse_playback.sv
// Directed bench for morse_playback with UNIT_CYCLES=4 and a 1-cycle-latency RAM model.
// Cycle i of a run is the i-th clock cycle after the edge that samples start.
module tb_morse_playback;
  import morse_pkg::*;

  localparam int unsigned ADDR_W = 4;
  localparam int MAXS = 120;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [ADDR_W-1:0] msg_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              led;
  logic              busy;
  logic              done;

  logic [7:0] ram [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-run capture and analysis results
  logic              led_h  [0:MAXS];
  logic              busy_h [0:MAXS];
  logic [ADDR_W-1:0] addr_h [0:MAXS];
  int done_idx, done_cnt, first_rise, n_runs, last_i;
  int on_len [0:3];
  int off_len[0:3];
  int busy_hi, busy_after, addr_nz;

  morse_playback #(
    .UNIT_CYCLES(4),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .start  (start),
    .msg_len(msg_len),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .led    (led),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= ram[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [ADDR_W-1:0] len);
    for (int k = 0; k < 16; k++) ram[k] = 8'h00;
    ram[0] = a;
    ram[1] = b;
    ram[2] = c;
    msg_len = len;
  endtask

  // Pulse start, record outputs each cycle until 4 cycles past done, then analyse.
  // start_at >= 1 raises start again during that cycle.
  task automatic run(input int start_at);
    int last_on;
    logic prev;
    done_idx = -1;
    done_cnt = 0;
    last_i   = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 1; i < MAXS; i++) begin
      led_h[i]  = led;
      busy_h[i] = busy;
      addr_h[i] = rd_addr;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      start  = (i == start_at);
      last_i = i;
      if (done_idx >= 0 && i >= done_idx + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_idx < 0) check("run_timeout", 32'd0, 32'd1);

    first_rise = -1;
    n_runs     = 0;
    last_on    = 0;
    prev       = 1'b0;
    busy_hi    = 0;
    busy_after = 0;
    addr_nz    = 0;
    for (int k = 0; k < 4; k++) begin
      on_len[k]  = 0;
      off_len[k] = 0;
    end
    for (int i = 1; i <= last_i; i++) begin
      if (led_h[i]) begin
        if (!prev) begin
          if (first_rise < 0) first_rise = i;
          if (n_runs > 0 && n_runs <= 4) off_len[n_runs-1] = i - last_on - 1;
          n_runs++;
        end
        if (n_runs <= 4) on_len[n_runs-1]++;
        last_on = i;
      end
      prev = led_h[i];
      if (busy_h[i] && (done_idx < 0 || i < done_idx)) busy_hi++;
      if (busy_h[i] && done_idx >= 0 && i > done_idx) busy_after++;
      if (addr_h[i] != '0) addr_nz++;
    end
  endtask

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    msg_len = '0;
    load3(8'h00, 8'h00, 8'h00, 4'd0);
    #12;
    check("rst_led",  32'(led),     32'd0);
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_done", 32'(done),    32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single dot: ON cycles 4..7, GAP 8..11, NEXT 12, DONE 13
    load3(SC_DOT, 8'h00, 8'h00, 4'd1);
    run(-1);
    check("t1_rise",      32'(first_rise), 32'd4);
    check("t1_runs",      32'(n_runs),     32'd1);
    check("t1_on",        32'(on_len[0]),  32'd4);
    check("t1_done_idx",  32'(done_idx),   32'd13);
    check("t1_done_cnt",  32'(done_cnt),   32'd1);
    check("t1_busy_hi",   32'(busy_hi),    32'd12);
    check("t1_busy_done", 32'(busy_h[13]), 32'd0);

    // Dash then dot: 12 on, 4 gap + 4 fetch overhead off, 4 on, 4 gap, NEXT, DONE at 33
    load3(SC_DASH, SC_DOT, 8'h00, 4'd2);
    run(-1);
    check("t2_rise",     32'(first_rise), 32'd4);
    check("t2_runs",     32'(n_runs),     32'd2);
    check("t2_on0",      32'(on_len[0]),  32'd12);
    check("t2_off0",     32'(off_len[0]), 32'd8);
    check("t2_on1",      32'(on_len[1]),  32'd4);
    check("t2_done_idx", 32'(done_idx),   32'd33);
    check("t2_addr0",    32'(addr_h[1]),  32'd0);
    check("t2_addr1",    32'(addr_h[21]), 32'd1);

    // Dot, space, dot: off between dots = 4 gap + 4 + 8 letter gap + 4 = 20
    load3(SC_DOT, SC_SPACE, SC_DOT, 4'd3);
    run(-1);
    check("t3_runs",     32'(n_runs),     32'd2);
    check("t3_on0",      32'(on_len[0]),  32'd4);
    check("t3_off0",     32'(off_len[0]), 32'd20);
    check("t3_on1",      32'(on_len[1]),  32'd4);
    check("t3_done_idx", 32'(done_idx),   32'd37);
    check("t3_done_cnt", 32'(done_cnt),   32'd1);

    // Unknown code costs only its fetch/decode cycles
    load3(8'h1C, SC_DOT, 8'h00, 4'd2);
    run(-1);
    check("t4_rise",     32'(first_rise), 32'd8);
    check("t4_runs",     32'(n_runs),     32'd1);
    check("t4_on",       32'(on_len[0]),  32'd4);
    check("t4_done_idx", 32'(done_idx),   32'd17);

    // Empty message: done one cycle after start, no RAM access
    load3(SC_DOT, 8'h00, 8'h00, 4'd0);
    run(-1);
    check("t5_done_idx", 32'(done_idx), 32'd1);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_runs",     32'(n_runs),   32'd0);
    check("t5_addr_nz",  32'(addr_nz),  32'd0);
    check("t5_busy",     32'(busy_hi + busy_after), 32'd0);

    // start during the DONE cycle must not launch another run
    load3(SC_DOT, 8'h00, 8'h00, 4'd1);
    run(13);
    check("t7_done_idx",   32'(done_idx),   32'd13);
    check("t7_busy_after", 32'(busy_after), 32'd0);
    check("t7_done_cnt",   32'(done_cnt),   32'd1);

    // Reset in the middle of a dash, after an ignored start while busy
    load3(SC_DASH, SC_DOT, 8'h00, 4'd2);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_led_mid", 32'(led), 32'd1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("t6_busy_ign", 32'(busy),    32'd1);
    check("t6_led_ign",  32'(led),     32'd1);
    check("t6_addr_ign", 32'(rd_addr), 32'd0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_led",  32'(led),  32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_idle", 32'(dut.state_q == ST_IDLE), 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done), 32'd0);
    run(-1);
    check("t6_rise",     32'(first_rise), 32'd4);
    check("t6_on0",      32'(on_len[0]),  32'd12);
    check("t6_on1",      32'(on_len[1]),  32'd4);
    check("t6_done_idx", 32'(done_idx),   32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
